// File: rtl/rr_mux_sched_pkg.sv
// Shared types and default sizing for the round-robin mux scheduler.
// Optional feature macro used by rr_mux_sched: RR_MUX_SCHED_BURST_EN.
package rr_mux_sched_pkg;

    localparam int DEF_N_REQ     = 16;
    localparam int DEF_SEL_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OFFER  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_mux_sched_pick.sv
// rr_pick: combinational round-robin picker. Searches req starting at
// last+1 and wrapping at N_REQ-1 -> 0; the first set bit wins.
module rr_pick
    import rr_mux_sched_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int SEL_WIDTH = DEF_SEL_WIDTH
) (
    input  logic [N_REQ-1:0]     req,
    input  logic [SEL_WIDTH-1:0] last,
    output logic [SEL_WIDTH-1:0] winner,
    output logic                 any
);

    logic [SEL_WIDTH:0] sum_s;
    logic [SEL_WIDTH:0] cand_s;

    // Walk candidates from farthest to nearest so the nearest requester after last overwrites the rest.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        sum_s  = '0;
        cand_s = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum_s  = {1'b0, last} + (SEL_WIDTH+1)'(i) + (SEL_WIDTH+1)'(1);
            cand_s = (sum_s >= (SEL_WIDTH+1)'(N_REQ)) ? (sum_s - (SEL_WIDTH+1)'(N_REQ)) : sum_s;
            winner = req[cand_s[SEL_WIDTH-1:0]] ? cand_s[SEL_WIDTH-1:0] : winner;
            any    = any | req[cand_s[SEL_WIDTH-1:0]];
        end
    end

endmodule

// File: rtl/rr_mux_sched.sv
// rr_mux_sched: round-robin scheduler driving the select of an external
// N_REQ:1 mux, sampling its output one cycle later and offering the sample
// downstream with a valid/ready handshake.
// Optional feature: define RR_MUX_SCHED_BURST_EN to let a granted requester
// keep the grant for up to MAX_BURST consecutive transfers.
module rr_mux_sched
    import rr_mux_sched_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int SEL_WIDTH = DEF_SEL_WIDTH,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    output logic [SEL_WIDTH-1:0] mux_sel,
    input  logic                 mux_out,
    output logic [N_REQ-1:0]     gnt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_data,
    output logic [SEL_WIDTH-1:0] out_src,
    output logic [N_REQ-1:0]     done
);

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_e                 state_q,     state_d;
    logic [SEL_WIDTH-1:0]   mux_sel_q,   mux_sel_d;
    logic [N_REQ-1:0]       gnt_q,       gnt_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_data_q,  out_data_d;
    logic [SEL_WIDTH-1:0]   out_src_q,   out_src_d;
    logic [N_REQ-1:0]       done_q,      done_d;
    logic [SEL_WIDTH-1:0]   last_q,      last_d;

    logic [SEL_WIDTH-1:0]   pick_winner_s;
    logic                   pick_any_s;

`ifdef RR_MUX_SCHED_BURST_EN
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;
`else
    logic                   unused_max_burst_s;
    assign unused_max_burst_s = (MAX_BURST != 32'sd0);
`endif

    rr_pick #(
        .N_REQ     (N_REQ),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick_winner_s),
        .any    (pick_any_s)
    );

    // Next-state and output computation for the IDLE/SETTLE/OFFER scheduler.
    always_comb begin
        state_d     = state_q;
        mux_sel_d   = mux_sel_q;
        gnt_d       = gnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        done_d      = '0;
        last_d      = last_q;
`ifdef RR_MUX_SCHED_BURST_EN
        burst_cnt_d = burst_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    mux_sel_d = pick_winner_s;
                    gnt_d     = onehot(pick_winner_s);
                    state_d   = SETTLE;
                end else begin
                    gnt_d     = '0;
                    state_d   = IDLE;
                end
            end
            SETTLE: begin
                // mux_out has had a full cycle to settle on the registered select.
                out_data_d  = mux_out;
                out_src_d   = mux_sel_q;
                out_valid_d = 1'b1;
                state_d     = OFFER;
            end
            OFFER: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = onehot(mux_sel_q);
                    last_d      = mux_sel_q;
`ifdef RR_MUX_SCHED_BURST_EN
                    if (req[mux_sel_q] && (burst_cnt_q < CNT_W'(MAX_BURST - 1))) begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                        state_d     = SETTLE;
                    end else begin
                        burst_cnt_d = '0;
                        gnt_d       = '0;
                        state_d     = IDLE;
                    end
`else
                    gnt_d       = '0;
                    state_d     = IDLE;
`endif
                end else begin
                    state_d = OFFER;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Scheduler state and output registers; reset discards any pending sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mux_sel_q   <= '0;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            out_src_q   <= '0;
            done_q      <= '0;
            last_q      <= SEL_WIDTH'(N_REQ - 1);
        end else begin
            state_q     <= state_d;
            mux_sel_q   <= mux_sel_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            done_q      <= done_d;
            last_q      <= last_d;
        end
    end

`ifdef RR_MUX_SCHED_BURST_EN
    // Counts extra transfers granted to the current owner within one burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`endif

    assign mux_sel   = mux_sel_q;
    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rr_mux_sched.sv
// Self-checking bench for rr_mux_sched: table of directed transfers,
// hand-written corner sequences and randomized transfers checked against
// a transaction-level round-robin model.
module tb_rr_mux_sched;

    localparam int MB = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [3:0]  mux_sel;
    logic        mux_out;
    logic [15:0] gnt;
    logic        out_valid;
    logic        out_ready;
    logic        out_data;
    logic [3:0]  out_src;
    logic [15:0] done;
    logic [15:0] mux_data;

    int checks;
    int errors;

    // Model state: last winner, and an open burst (grant kept across a handshake).
    int   m_last;
    logic m_pending;
    int   m_cnt;
    int   m_sel;

    typedef struct {
        logic [15:0] r;
        int          exp_w;
    } vec_t;

    vec_t vecs [10];
    int   n_vec;

    rr_mux_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mux_sel   (mux_sel),
        .mux_out   (mux_out),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .done      (done)
    );

    // External N:1 mux modelled combinationally from the DUT select.
    assign mux_out = mux_data[mux_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_next(input logic [15:0] r, input int last);
        for (int k = 1; k <= 16; k++) begin
            if (r[(last + k) % 16]) return (last + k) % 16;
        end
        return -1;
    endfunction

    function automatic logic [15:0] oh(input int i);
        return 16'h0001 << i;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_last    = 15;
        m_pending = 1'b0;
        m_cnt     = 0;
        m_sel     = 0;
    endtask

    // One full transfer: grant, settle/capture, optional stall, handshake.
    task automatic xfer(input logic [15:0] r, input logic [15:0] r_during, input int wait_n, input int exp_w);
        int   w;
        logic exp_bit;
        req       = r;
        out_ready = 1'b0;
        if (m_pending) begin
            w = m_sel;
        end else begin
            w = rr_next(r, m_last);
            tick;
            chk("dec_done", 32'(done), 32'h0);
            chk("dec_valid", 32'(out_valid), 32'h0);
        end
        if (exp_w >= 0) w = exp_w;
        chk("grant_sel", 32'(mux_sel), 32'(w));
        chk("grant_gnt", 32'(gnt), 32'(oh(w)));
        req     = r_during;
        exp_bit = mux_data[w];
        tick;
        chk("cap_valid", 32'(out_valid), 32'h1);
        chk("cap_data", 32'(out_data), 32'(exp_bit));
        chk("cap_src", 32'(out_src), 32'(w));
        chk("cap_gnt", 32'(gnt), 32'(oh(w)));
        chk("cap_done", 32'(done), 32'h0);
        for (int i = 0; i < wait_n; i++) begin
            mux_data = 16'($urandom);
            req      = 16'($urandom);
            tick;
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_data", 32'(out_data), 32'(exp_bit));
            chk("stall_sel", 32'(mux_sel), 32'(w));
            chk("stall_gnt", 32'(gnt), 32'(oh(w)));
            chk("stall_done", 32'(done), 32'h0);
        end
        req       = r_during;
        out_ready = 1'b1;
        tick;
        chk("hs_done", 32'(done), 32'(oh(w)));
        chk("hs_valid", 32'(out_valid), 32'h0);
        m_last = w;
`ifdef RR_MUX_SCHED_BURST_EN
        if (r_during[w] && (m_cnt < MB - 1)) begin
            m_cnt     = m_cnt + 1;
            m_pending = 1'b1;
            m_sel     = w;
            chk("hs_gnt_burst", 32'(gnt), 32'(oh(w)));
        end else begin
            m_cnt     = 0;
            m_pending = 1'b0;
            chk("hs_gnt", 32'(gnt), 32'h0);
        end
`else
        chk("hs_gnt", 32'(gnt), 32'h0);
`endif
        out_ready = 1'b0;
    endtask

    task automatic flush;
        while (m_pending) xfer(16'h0000, 16'h0000, 0, -1);
    endtask

    task automatic idle_chk(input int n);
        req       = 16'h0000;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick;
            chk("idle_gnt", 32'(gnt), 32'h0);
            chk("idle_valid", 32'(out_valid), 32'h0);
            chk("idle_done", 32'(done), 32'h0);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] r;
        logic [15:0] rd;
        int          w;
        checks    = 0;
        errors    = 0;
        req       = 16'h0000;
        out_ready = 1'b0;
        mux_data  = 16'h0000;
        rst_n     = 1'b0;
        model_reset();

`ifdef RR_MUX_SCHED_BURST_EN
        n_vec = 8;
        for (int i = 0; i < 8; i++) begin
            vecs[i].r     = 16'h0006;
            vecs[i].exp_w = (i < 4) ? 1 : 2;
        end
`else
        n_vec = 10;
        vecs[0] = '{16'h0021, 0};
        vecs[1] = '{16'h0021, 5};
        vecs[2] = '{16'h0021, 0};
        vecs[3] = '{16'h8000, 15};
        vecs[4] = '{16'h8001, 0};
        vecs[5] = '{16'h0006, 1};
        vecs[6] = '{16'h0006, 2};
        vecs[7] = '{16'h0006, 1};
        vecs[8] = '{16'h0006, 2};
        vecs[9] = '{16'h0000, -1};
`endif

        // Reset state, checked before any clock edge.
        #3;
        chk("rst_sel", 32'(mux_sel), 32'h0);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_src", 32'(out_src), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        tick;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < n_vec; i++) begin
            if (vecs[i].exp_w >= 0) begin
                mux_data = 16'($urandom);
                xfer(vecs[i].r, vecs[i].r, 0, vecs[i].exp_w);
            end
        end
        flush();

        // out_ready without out_valid does nothing.
        idle_chk(3);

        // Long stall with mux_out toggling underneath.
        mux_data = 16'h0400;
        xfer(16'h0400, 16'h0400, 10, -1);
        flush();

        // Requester drops during SETTLE; transfer still completes.
        xfer(16'h0008, 16'h0000, 0, 3);
        flush();
        idle_chk(2);

        // Randomized transfers against the model.
        for (int t = 0; t < 40; t++) begin
            r        = (16'($urandom) & 16'($urandom)) | oh($urandom_range(0, 15));
            rd       = ($urandom_range(0, 1) == 1) ? r : 16'($urandom);
            mux_data = 16'($urandom);
            xfer(r, rd, $urandom_range(0, 3), -1);
        end
        flush();

        // Asynchronous reset during OFFER discards the sample.
        mux_data  = 16'hFFFF;
        req       = 16'h0030;
        out_ready = 1'b0;
        w         = rr_next(16'h0030, m_last);
        tick;
        chk("ar_sel", 32'(mux_sel), 32'(w));
        tick;
        chk("ar_valid_pre", 32'(out_valid), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_sel0", 32'(mux_sel), 32'h0);
        chk("ar_gnt0", 32'(gnt), 32'h0);
        chk("ar_valid0", 32'(out_valid), 32'h0);
        chk("ar_data0", 32'(out_data), 32'h0);
        chk("ar_src0", 32'(out_src), 32'h0);
        chk("ar_done0", 32'(done), 32'h0);
        out_ready = 1'b1;
        tick;
        chk("ar_done_hold", 32'(done), 32'h0);
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        xfer(16'h0030, 16'h0030, 0, 4);
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_sched.md
RR_MUX_SCHED -- requirements
Module: rr_mux_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 16, number of requesters (mux inputs).
REQ-002 SHALL have parameter SEL_WIDTH, default 4, select width, equal to log2(N_REQ).
REQ-003 SHALL have parameter MAX_BURST, default 4, max consecutive transfers per grant; used only with burst enabled.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req, input, N_REQ, per-requester request, level-sensitive.
REQ-007 SHALL have port mux_sel, output, SEL_WIDTH, registered select driven to the external N_REQ:1 mux.
REQ-008 SHALL have port mux_out, input, 1, external mux output, combinational from mux_sel.
REQ-009 SHALL have port gnt, output, N_REQ, registered one-hot grant; all-zero when idle.
REQ-010 SHALL have port out_valid, output, 1, captured sample available.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the sample.
REQ-012 SHALL have port out_data, output, 1, registered sample of mux_out.
REQ-013 SHALL have port out_src, output, SEL_WIDTH, index of the requester that produced out_data.
REQ-014 SHALL have port done, output, N_REQ, one-cycle one-hot pulse on each accepted transfer.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, OFFER.
REQ-016 IDLE: if req nonzero, pick winner round-robin starting at last+1 (mod N_REQ); load mux_sel and gnt; go to SETTLE. If req is zero, stay in IDLE with gnt=0.
REQ-017 SETTLE: exactly one cycle; capture mux_out into out_data and mux_sel into out_src; set out_valid=1; go to OFFER.
REQ-018 OFFER: hold out_valid, out_data, out_src and mux_sel stable until out_valid && out_ready.
REQ-019 On handshake: out_valid=0; done[mux_sel]=1 for one cycle; last=mux_sel; gnt cleared; go to IDLE (burst rules in REQ-029).
REQ-020 Latency: req seen in IDLE at cycle 0 -> out_valid=1 at cycle 2; a handshake at cycle n allows a new grant decision at cycle n+1.
REQ-021 Once granted, a transfer SHALL complete even if req[winner] drops; withdrawal only affects the next arbitration.
REQ-022 req changes during SETTLE or OFFER SHALL NOT alter mux_sel or gnt.
REQ-023 Single requester repeatedly asserting SHALL be re-granted every transfer.
REQ-024 last pointer wraps N_REQ-1 -> 0; winner search wraps identically.
REQ-025 out_ready asserted without out_valid SHALL have no effect.

Reset
REQ-026 rst_n low SHALL asynchronously force: state=IDLE, mux_sel=0, gnt=0, out_valid=0, out_data=0, out_src=0, done=0, last=N_REQ-1, burst count=0.
REQ-027 Reset mid-transfer SHALL discard the pending sample with no done pulse; the first grant after reset goes to the lowest requesting index.

Configuration
REQ-028 Macro RR_MUX_SCHED_BURST_EN SHALL select burst mode.
REQ-029 With the macro: on handshake, if req[mux_sel] is still high and the burst count is below MAX_BURST-1, go to SETTLE keeping mux_sel and gnt and increment the count. Otherwise clear the count and go to IDLE. Each transfer pulses done.
REQ-030 Without the macro: no burst counter; every handshake returns to IDLE (one transfer per grant); MAX_BURST is ignored.

Structure
REQ-031 Package rr_mux_sched_pkg SHALL hold the state enum (IDLE/SETTLE/OFFER) and the default N_REQ/SEL_WIDTH constants.
REQ-032 Sub-module rr_pick SHALL be the combinational round-robin picker: inputs req and last; outputs winner index and any.

Verification
REQ-033 After reset, req=16'h0021 with out_ready=1: grant 0 then 5 then 0; out_src sequence 0,5,0; out_valid at cycle 2 after the first req.
REQ-034 req=16'h8000, last=15 after reset: grant wraps to 15 (search 0..15); then req=16'h8001: next grant is 0.
REQ-035 out_ready held 0 for 10 cycles in OFFER while mux_out toggles: out_data, mux_sel and out_valid remain stable; one done pulse after out_ready=1.
REQ-036 req[3] dropped during SETTLE: the transfer completes, done[3] pulses once, and the FSM returns to IDLE.
REQ-037 rst_n pulsed low during OFFER: outputs are zero immediately without waiting for clk; no done pulse; next grant goes to the lowest requester.
REQ-038 With RR_MUX_SCHED_BURST_EN, MAX_BURST=4, and req=16'h0006 held: four transfers from 1, then four from 2. Without the macro: 1,2,1,2 alternating.
